// File: rtl/mult_arb_pkg.sv
// Shared constants, FSM encodings and the round-robin pick function for mult_arbiter.
package mult_arb_pkg;

   localparam int unsigned DEF_N_REQ = 4;
   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned MAX_REQ   = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // One-hot grant to the first valid requester at or after ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int unsigned        n);
      logic [MAX_REQ-1:0] grant;
      logic               found;
      logic [2:0]         idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = 3'((32'(ptr) + i) % n);
         if (i < n && !found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle, fixed WIDTH steps.
module shift_add_mult #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   x_q, y_q;
   logic [2*WIDTH-1:0] acc_q, acc_d, partial;
   logic [CW-1:0]      cnt_q;
   logic               run_q;

   always_comb begin
      partial = '0;
      if (y_q[cnt_q]) partial = {{WIDTH{1'b0}}, x_q} << cnt_q;
      acc_d = acc_q + partial;
   end

   // done and product describe the step being taken this cycle, so the owner
   // can capture the final sum on the same edge that completes it.
   assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
   assign product = acc_d;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         x_q   <= '0;
         y_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         x_q   <= x;
         y_q   <= y;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CW'(1);
         if (done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one shift-add multiplier and returns product plus ID.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int unsigned N_REQ = DEF_N_REQ,
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_x,
   input  logic [N_REQ*WIDTH-1:0] req_y,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [2*WIDTH-1:0]     rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);

   logic [1:0]         state_q, state_d;
   logic [ID_W-1:0]    ptr, id_q, rsp_id_q, gidx;
   logic [2*WIDTH-1:0] rsp_data_q, mult_product;
   logic [MAX_REQ-1:0] valid_pad, pick;
   logic               unused_pick;
   logic [WIDTH-1:0]   sel_x, sel_y;
   logic               accept, mult_done;

`ifdef MULT_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   logic [ID_W-1:0] ptr_q;
   assign ptr = ptr_q;

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (state_q == DONE && rsp_ready) begin
         ptr_q <= (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
      end
   end
`endif

   always_comb begin
      valid_pad              = '0;
      valid_pad[N_REQ-1:0]   = req_valid;
   end

   assign pick        = rr_pick(valid_pad, 3'(ptr), N_REQ);
   assign unused_pick = ^pick;
   // Gated by rst_n so no grant is offered while reset is held.
   assign req_ready   = (rst_n && state_q == IDLE) ? pick[N_REQ-1:0] : '0;
   assign accept      = |(req_valid & req_ready);

   always_comb begin
      gidx  = '0;
      sel_x = '0;
      sel_y = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req_ready[i]) begin
            gidx  = ID_W'(i);
            sel_x = req_x[i*WIDTH +: WIDTH];
            sel_y = req_y[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CALC;
         CALC:    if (mult_done) state_d = DONE;
         DONE:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         id_q       <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) id_q <= gidx;
         if (state_q == CALC && mult_done) begin
            rsp_data_q <= mult_product;
            rsp_id_q   <= id_q;
         end
      end
   end

   shift_add_mult #(
      .WIDTH(WIDTH)
   ) u_mult (
      .clock   (clock),
      .rst_n   (rst_n),
      .start   (accept),
      .x       (sel_x),
      .y       (sel_y),
      .done    (mult_done),
      .product (mult_product)
   );

   assign rsp_valid = (state_q == DONE);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter (default 4 requesters x 8 bits).
module tb_mult_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 8;
   localparam int unsigned IW = 2;

   logic             clock = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid, req_ready;
   logic [N*W-1:0]   req_x, req_y;
   logic             rsp_valid, rsp_ready;
   logic [2*W-1:0]   rsp_data;
   logic [IW-1:0]    rsp_id;
   logic             busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   mult_arbiter #(
      .N_REQ(N),
      .WIDTH(W)
   ) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Returns the index being granted this cycle, or -1 after the budget expires.
   task automatic wait_accept(input string tag, output int idx);
      idx = -1;
      #1;
      for (int c = 0; c < 30; c++) begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) idx = i;
         if (idx >= 0) return;
         tick();
      end
      check({tag, "_accept_timeout"}, 0, 1);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_one(input string tag, input int i, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp);
      int idx, lat;
      set_ops(i, x, y);
      req_valid = N'(1 << i);
      rsp_ready = 1'b1;
      wait_accept(tag, idx);
      check({tag, "_grant"}, idx, i);
      tick();
      req_valid = '0;
      check({tag, "_busy"}, busy, 1);
      wait_rsp(lat);
      check({tag, "_latency"}, lat, 8);
      check({tag, "_data"}, rsp_data, exp);
      check({tag, "_id"}, rsp_id, i);
      tick();
      check({tag, "_rsp_drop"}, rsp_valid, 0);
   endtask

   int exp_order[5];
   int prod[4] = '{15, 24, 35, 48};
   int idx, lat, last, bad;
   logic [N-1:0] bp_ready;
   int bp_second;

   initial begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
      bp_ready  = 4'b0001;
      bp_second = 63;
`else
      exp_order = '{0, 1, 2, 3, 0};
      bp_ready  = 4'b0010;
      bp_second = 30;
`endif
      req_valid = '1;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b1;

      // Reset state, with every requester asking
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_busy", busy, 0);
      rst_n     = 1'b1;
      req_valid = '0;
      tick();

      // Single multiply and extremes
      run_one("single", 0, 8'd13, 8'd11, 143);
      run_one("max", 1, 8'd255, 8'd255, 65025);
      run_one("zero", 3, 8'd0, 8'd200, 0);
      run_one("pow2", 0, 8'd1, 8'd128, 128);

      // Fairness with all requesters continuously valid
      do_reset();
      for (int i = 0; i < N; i++) set_ops(i, W'(i + 3), W'(i + 5));
      req_valid = '1;
      rsp_ready = 1'b1;
      last      = 0;
      for (int k = 0; k < 5; k++) begin
         wait_accept("rr", idx);
         check($sformatf("rr_order%0d", k), idx, exp_order[k]);
         if (k > 0) check($sformatf("rr_gap%0d", k), cyc - last, 10);
         last = cyc;
         tick();
         wait_rsp(lat);
         check($sformatf("rr_data%0d", k), rsp_data, prod[exp_order[k]]);
         check($sformatf("rr_id%0d", k), rsp_id, exp_order[k]);
         tick();
      end
      req_valid = '0;

      // Back-pressure: 20 stalled cycles in DONE
      do_reset();
      set_ops(0, 8'd7, 8'd9);
      set_ops(1, 8'd6, 8'd5);
      req_valid = 4'b0011;
      rsp_ready = 1'b0;
      wait_accept("bp", idx);
      check("bp_grant", idx, 0);
      tick();
      wait_rsp(lat);
      check("bp_data", rsp_data, 63);
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== 16'd63 || rsp_id !== 2'd0 ||
             req_ready !== 4'b0000 || busy !== 1'b1) bad++;
      end
      check("bp_stable_cycles_bad", bad, 0);
      rsp_ready = 1'b1;
      #1;
      check("bp_no_accept_at_handshake", req_ready, 0);
      tick();
      rsp_ready = 1'b0;
      #1;
      check("bp_next_ready", req_ready, bp_ready);
      check("bp_rsp_valid_low", rsp_valid, 0);
      tick();
      req_valid = '0;
      wait_rsp(lat);
      check("bp_second_data", rsp_data, bp_second);
      rsp_ready = 1'b1;
      tick();

      // Reset in CALC cycle 4 discards the operation and the pointer
      do_reset();
      run_one("pre", 1, 8'd3, 8'd4, 12);
      set_ops(0, 8'd10, 8'd10);
      set_ops(2, 8'd50, 8'd2);
      req_valid = 4'b0100;
      wait_accept("mid", idx);
      check("mid_grant", idx, 2);
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_rsp_data", rsp_data, 0);
      check("mid_rsp_id", rsp_id, 0);
      check("mid_req_ready", req_ready, 0);
      rst_n = 1'b1;
      bad   = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (rsp_valid !== 1'b0) bad++;
      end
      check("mid_no_response", bad, 0);
      req_valid = 4'b0101;
      #1;
      check("mid_ptr_reset_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      wait_rsp(lat);
      check("mid_after_data", rsp_data, 100);
      tick();

      // Operands change after accept
      set_ops(2, 8'd21, 8'd12);
      req_valid = 4'b0100;
      wait_accept("opchg", idx);
      tick();
      req_valid = '0;
      set_ops(2, 8'd99, 8'd77);
      tick();
      set_ops(2, 8'd255, 8'd3);
      wait_rsp(lat);
      check("opchg_data", rsp_data, 252);
      check("opchg_id", rsp_id, 2);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one sequential shift-add unsigned multiplier between `N_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester at a time, runs a fixed-latency multiply (one multiplier bit per cycle), and returns the product with the requester's ID on a single response channel. It sits between the switch/button front-ends (or any operand sources) and the LED/display sink.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand width; product is `2*WIDTH`.
- `ID_W`, default `$clog2(N_REQ)`: response ID width.

Ports:
- `clock`, in, 1: single clock; all logic on posedge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, `N_REQ`: per-requester operand valid.
- `req_ready`, out, `N_REQ`: per-requester grant/accept, one-hot or zero.
- `req_x`, in, `N_REQ*WIDTH`: multiplicands; requester i occupies `[i*WIDTH +: WIDTH]`.
- `req_y`, in, `N_REQ*WIDTH`: multipliers, packed the same way.
- `rsp_valid`, out, 1: product available.
- `rsp_ready`, in, 1: sink accepts product.
- `rsp_data`, out, `2*WIDTH`: unsigned product x*y.
- `rsp_id`, out, `ID_W`: index of the requester that owns `rsp_data`.
- `busy`, out, 1: high in CALC or DONE.

## Operation
- FSM states:
  - IDLE: grant logic active.
  - CALC: multiplying.
  - DONE: response held.
- IDLE:
  - `req_ready` is driven combinationally, one-hot to the winning requester among those with `req_valid` high.
  - On `req_valid[g] & req_ready[g]`, latch `x`, `y`, and `g` as the ID, clear the accumulator and the bit counter, and go to CALC.
- Arbitration is round-robin. Search starts at pointer `ptr`, the index after the last served ID. `ptr` resets to 0 and updates when the response handshake completes.
- CALC:
  - Step k (k = 0..WIDTH-1) adds `x << k` to the accumulator if `y[k]` is set.
  - After step WIDTH-1, go to DONE.
  - Run all WIDTH steps regardless of operand values; do not exit early on zero.
- Accumulator is `2*WIDTH` bits, unsigned. Overflow is impossible.
- DONE:
  - `rsp_valid` = 1, and `rsp_data` and `rsp_id` are stable.
  - On `rsp_ready`, go to IDLE and set `ptr` = ID+1 mod `N_REQ`.
- `req_ready` is all zero outside IDLE. Requests wait; nothing is dropped or queued internally.
- Requesters may change operands freely while not handshaking; only the accepted cycle is sampled.

## Timing
- Reset values: state IDLE, `req_ready` = 0 (combinational, so zero while `rst_n` = 0), `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0, `ptr` = 0.
- Latency: if the accept occurs at edge E0, `rsp_valid` rises after edge E_WIDTH, which is 8 cycles for the default.
- Throughput: one product per WIDTH+2 cycles minimum, covering the accept cycle, WIDTH CALC cycles, and one DONE cycle when `rsp_ready` is already high.
- A response handshake and a new accept never occur in the same cycle. The next accept is no earlier than the cycle after the return to IDLE.
- `rsp_ready` held low stalls indefinitely in DONE with outputs constant.
- If `req_valid` drops in IDLE before a grant, the arbiter re-evaluates the next cycle with no penalty.
- Reset mid-CALC or mid-DONE discards the operation with no response.
- `rsp_data` and `rsp_id` hold their last value in IDLE and CALC; they are only meaningful with `rsp_valid`.

## Configuration
- `MULT_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `ptr` is unused and tied to 0.
  - Undefined (default): round-robin as above.
- Latency and handshake behaviour are identical in both modes.

## Structure
- Package `mult_arb_pkg`:
  - FSM state enum `{IDLE, CALC, DONE}`.
  - Default `N_REQ`/`WIDTH` constants.
  - Function for the round-robin one-hot pick.
- Sub-module `shift_add_mult`: the shift-add unit, with `start`, `x`, `y` in and `done`, `product` out, and a WIDTH-step counter.
- `mult_arbiter` owns arbitration, the ID register, and the response channel.

## Test plan
- **Single multiply:** requester 0 sends x=13, y=11 with `rsp_ready` high. Require `rsp_data`=143, `rsp_id`=0, and `rsp_valid` 8 cycles after accept.
- **Extremes:** x=255, y=255 gives 65025. x=0, y=200 gives 0 with the same 8-cycle latency. x=1, y=128 gives 128.
- **Round-robin fairness:** all 4 requesters hold `req_valid` continuously. Require grant order 0,1,2,3,0. With `MULT_ARB_FIXED_PRIO_EN` defined, require 0 every time.
- **Back-pressure:** hold `rsp_ready`=0 for 20 cycles after `rsp_valid`. Require outputs constant, all `req_ready` low, and the next accept only after `rsp_ready` pulses.
- **Reset mid-operation:** assert `rst_n`=0 in CALC cycle 4. Require all outputs at reset values next cycle, no response, and `ptr`=0 (next grant to requester 0).
- **Operand change after accept:** change requester 2's `req_x`/`req_y` during CALC. Require the product to use the values sampled at accept and `rsp_id`=2.
